mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max BUSY cycles without s_ready before forced error completion; legal range 1..65535.
REQ-002 Parameter ERR_RDATA, default 32'hDEADBEEF: read data returned on timeout.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 m0_valid, m1_valid  input  1 each  requester N has a request pending (picorv32 native bus).
REQ-006 m0_addr, m1_addr  input  32 each  requester byte address.
REQ-007 m0_wdata, m1_wdata  input  32 each  requester write data.
REQ-008 m0_wstrb, m1_wstrb  input  4 each  byte write strobes; 0 means read.
REQ-009 m0_ready, m1_ready  output  1 each  one-cycle completion pulse to requester N.
REQ-010 m0_rdata, m1_rdata  output  32 each  read data, valid when mN_ready=1.
REQ-011 s_valid  output  1  downstream request.
REQ-012 s_addr, s_wdata  output  32 each; s_wstrb  output  4  downstream request fields.
REQ-013 s_rdata  input  32; s_ready  input  1  downstream completion.
REQ-014 grant  output  1  index of the requester currently or last served.
REQ-015 timeout_err  output  1  one-cycle pulse on forced timeout completion.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-017 In IDLE with exactly one mN_valid=1, the arbiter SHALL set grant=N and enter BUSY on the next edge.
REQ-018 In IDLE with both valids=1, the arbiter SHALL grant the requester not equal to last_grant (round-robin), then update last_grant.
REQ-019 In IDLE with no valid, the state and grant SHALL hold.
REQ-020 s_valid SHALL equal (state==BUSY); s_addr/s_wdata/s_wstrb SHALL combinationally mux the granted requester's fields; in IDLE these SHALL be 0.
REQ-021 m{grant}_ready SHALL equal s_ready AND state==BUSY; the non-granted ready SHALL be 0; m{grant}_rdata SHALL pass s_rdata through combinationally.
REQ-022 Latency: request at cycle 0 in IDLE -> s_valid at cycle 1 -> mN_ready in the same cycle as s_ready; minimum 2 cycles per transaction.
REQ-023 On s_ready in BUSY, the FSM SHALL return to IDLE on the next edge (one mandatory idle cycle between transactions).
REQ-024 A 16-bit cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle without s_ready.
REQ-025 When the counter equals TIMEOUT_CYCLES-1 and s_ready=0, the arbiter SHALL assert m{grant}_ready with rdata=ERR_RDATA, pulse timeout_err, and return to IDLE.
REQ-026 If s_ready and the timeout condition coincide, s_ready SHALL win; timeout_err stays 0 and rdata = s_rdata.
REQ-027 If the granted requester drops valid while in BUSY, the arbiter SHALL deassert s_valid combinationally, return to IDLE next edge, and emit no ready.
REQ-028 Writes on timeout SHALL also complete with ready=1 (write discarded downstream).

Reset
REQ-029 While resetn=0 at a rising edge: state=IDLE, counter=0, last_grant=1 (m0 wins first tie), grant=0.
REQ-030 Consequently all outputs SHALL read 0 the cycle after reset, including mid-transaction reset; no ready SHALL be issued for an interrupted transaction.

Structure
REQ-031 Shared package mem_bus_pkg SHALL hold the state enum, ERR_RDATA default, and the bus-map constants (RAM base 32'h00000000, UART base 32'h02000000).
REQ-032 The timeout counter SHALL be a sub-module mem_bus_watchdog (inputs clear/enable, output expired); arbitration stays in the top module.

Verification
REQ-033 Single read: m0 reads 0x100, slave replies s_rdata=0x12345678 after 3 cycles -> m0_ready one pulse, m0_rdata=0x12345678, m1_ready=0.
REQ-034 Tie after reset: m0 and m1 valid in the same cycle -> m0 served first, m1 second; repeat tie -> order m0, m1 alternates per round-robin.
REQ-035 Timeout: TIMEOUT_CYCLES=8, slave never readies -> m1_ready and timeout_err pulse exactly 8 BUSY cycles after grant, m1_rdata=0xDEADBEEF.
REQ-036 Coincident: s_ready asserted on the 8th BUSY cycle -> timeout_err=0, rdata=s_rdata.
REQ-037 Byte write: m1 writes 0x02000000 wstrb=4'b0001 wdata=0x41 -> s_wstrb=4'b0001, s_addr=0x02000000 during BUSY, one m1_ready.
REQ-038 Reset mid-BUSY: resetn=0 for one cycle while s_valid=1 -> next cycle s_valid=0, no mN_ready, subsequent tie goes to m0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strb_t;

  localparam int    CNT_W             = 16;
  localparam word_t ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  // System bus map
  localparam word_t RAM_BASE  = 32'h0000_0000;
  localparam word_t UART_BASE = 32'h0200_0000;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester (picorv32 native) and downstream bus signals of the arbiter.
interface mem_bus_arbiter_if;
  import mem_bus_pkg::*;

  logic  m0_valid, m1_valid;
  word_t m0_addr,  m1_addr;
  word_t m0_wdata, m1_wdata;
  strb_t m0_wstrb, m1_wstrb;
  logic  m0_ready, m1_ready;
  word_t m0_rdata, m1_rdata;

  logic  s_valid;
  word_t s_addr, s_wdata;
  strb_t s_wstrb;
  word_t s_rdata;
  logic  s_ready;

  logic  grant;
  logic  timeout_err;

  // Arbiter side: takes requests, masters the downstream bus.
  modport master (
    input  m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_wstrb, m1_wstrb,
    input  s_rdata, s_ready,
    output m0_ready, m1_ready, m0_rdata, m1_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb, grant, timeout_err
  );

  // Environment side: requesters plus downstream slave.
  modport slave (
    output m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_wstrb, m1_wstrb,
    output s_rdata, s_ready,
    input  m0_ready, m1_ready, m0_rdata, m1_rdata,
    input  s_valid, s_addr, s_wdata, s_wstrb, grant, timeout_err
  );

endinterface

// File: rtl/mem_bus_watchdog.sv
// BUSY-cycle counter; expired is high once LIMIT-1 stalled cycles have elapsed.
module mem_bus_watchdog
  import mem_bus_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a held enable never wraps back below the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one downstream bus between two picorv32-style requesters,
// with a watchdog that force-completes stalled transfers.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter word_t       ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic               clk,
  input  logic               resetn,
  mem_bus_arbiter_if.master  bus
);

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;

  logic   busy;
  logic   sel_valid;
  logic   start;
  logic   expired;
  logic   complete;
  word_t  rdata_mux;

  assign busy      = (state_q == ST_BUSY);
  assign sel_valid = grant_q ? bus.m1_valid : bus.m0_valid;
  assign start     = (state_q == ST_IDLE) && (bus.m0_valid || bus.m1_valid);

  mem_bus_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (start),
    .enable  (busy && !bus.s_ready),
    .expired (expired)
  );

  // last_grant only records tie outcomes; single requests leave it alone.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.m0_valid && bus.m1_valid) begin
          grant_d      = ~last_grant_q;
          last_grant_d = ~last_grant_q;
          state_d      = ST_BUSY;
        end else if (bus.m0_valid) begin
          grant_d = 1'b0;
          state_d = ST_BUSY;
        end else if (bus.m1_valid) begin
          grant_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!sel_valid || bus.s_ready || expired) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // A real s_ready always beats a coincident timeout.
  always_comb begin
    bus.s_valid     = 1'b0;
    bus.s_addr      = '0;
    bus.s_wdata     = '0;
    bus.s_wstrb     = '0;
    bus.m0_ready    = 1'b0;
    bus.m1_ready    = 1'b0;
    bus.m0_rdata    = '0;
    bus.m1_rdata    = '0;
    bus.timeout_err = 1'b0;
    complete        = 1'b0;
    rdata_mux       = '0;
    if (busy) begin
      bus.s_valid     = sel_valid;
      bus.s_addr      = grant_q ? bus.m1_addr  : bus.m0_addr;
      bus.s_wdata     = grant_q ? bus.m1_wdata : bus.m0_wdata;
      bus.s_wstrb     = grant_q ? bus.m1_wstrb : bus.m0_wstrb;
      bus.timeout_err = sel_valid && !bus.s_ready && expired;
      complete        = sel_valid && (bus.s_ready || expired);
      rdata_mux       = bus.timeout_err ? ERR_RDATA : bus.s_rdata;
      if (grant_q) begin
        bus.m1_ready = complete;
        bus.m1_rdata = rdata_mux;
      end else begin
        bus.m0_ready = complete;
        bus.m0_rdata = rdata_mux;
      end
    end
  end

  assign bus.grant = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (32'hDEADBEEF)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: who owns the bus, how many BUSY cycles it has lasted, who wins the next tie.
  bit mdl_ok = 0;
  bit m_busy = 0;
  int m_owner = 0;
  int m_age = 0;
  int m_pref = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy = 0; m_owner = 0; m_age = 0; m_pref = 0; mdl_ok = 1;
    end else if (!m_busy) begin
      if (bus.m0_valid && bus.m1_valid) begin
        m_owner = m_pref; m_pref = 1 - m_owner; m_busy = 1; m_age = 1;
      end else if (bus.m0_valid) begin
        m_owner = 0; m_busy = 1; m_age = 1;
      end else if (bus.m1_valid) begin
        m_owner = 1; m_busy = 1; m_age = 1;
      end
    end else begin
      if (!(m_owner == 1 ? bus.m1_valid : bus.m0_valid) || bus.s_ready || m_age == TO)
        m_busy = 0;
      else
        m_age++;
    end
  end

  // Completion log for the directed checks.
  int          done_who[$];
  logic [31:0] done_rd[$];
  logic        done_to[$];

  always @(negedge clk) begin : cmp
    logic        ov, ev, to, dn;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_wstrb;
    if (mdl_ok) begin
      ov      = (m_owner == 1) ? bus.m1_valid : bus.m0_valid;
      ev      = m_busy && ov;
      to      = ev && !bus.s_ready && (m_age == TO);
      dn      = ev && (bus.s_ready || m_age == TO);
      e_addr  = !m_busy ? 32'h0 : (m_owner == 1 ? bus.m1_addr  : bus.m0_addr);
      e_wdata = !m_busy ? 32'h0 : (m_owner == 1 ? bus.m1_wdata : bus.m0_wdata);
      e_wstrb = !m_busy ? 4'h0  : (m_owner == 1 ? bus.m1_wstrb : bus.m0_wstrb);
      e_rd    = !m_busy ? 32'h0 : (to ? 32'hDEADBEEF : bus.s_rdata);
      chk("s_valid",     {31'b0, bus.s_valid}, {31'b0, ev});
      chk("s_addr",      bus.s_addr, e_addr);
      chk("s_wdata",     bus.s_wdata, e_wdata);
      chk("s_wstrb",     {28'b0, bus.s_wstrb}, {28'b0, e_wstrb});
      chk("grant",       {31'b0, bus.grant}, 32'(m_owner));
      chk("timeout_err", {31'b0, bus.timeout_err}, {31'b0, to});
      chk("m0_ready",    {31'b0, bus.m0_ready}, {31'b0, dn && m_owner == 0});
      chk("m1_ready",    {31'b0, bus.m1_ready}, {31'b0, dn && m_owner == 1});
      chk("m0_rdata",    bus.m0_rdata, (m_owner == 0) ? e_rd : 32'h0);
      chk("m1_rdata",    bus.m1_rdata, (m_owner == 1) ? e_rd : 32'h0);
      if (bus.m0_ready) begin done_who.push_back(0); done_rd.push_back(bus.m0_rdata); done_to.push_back(bus.timeout_err); end
      if (bus.m1_ready) begin done_who.push_back(1); done_rd.push_back(bus.m1_rdata); done_to.push_back(bus.timeout_err); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_svalid(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.s_valid) begin ok = 1; break; end
      tick();
    end
    chk("wait_s_valid", {31'b0, ok}, 32'h1);
  endtask

  // Reply with s_ready on the d-th BUSY cycle, then retire the served requester.
  task automatic serve(input int d, input logic [31:0] rd);
    bit ok;
    bit w0, w1;
    wait_svalid(ok);
    if (ok) begin
      repeat (d - 1) tick();
      bus.s_ready = 1'b1;
      bus.s_rdata = rd;
      #1;
      w0 = bus.m0_ready;
      w1 = bus.m1_ready;
      tick();
      if (w0) bus.m0_valid = 1'b0;
      if (w1) bus.m1_valid = 1'b0;
      bus.s_ready = 1'b0;
      bus.s_rdata = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got expired want finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int n0;
    int n;
    bus.m0_valid = 0; bus.m1_valid = 0;
    bus.m0_addr = 0; bus.m1_addr = 0; bus.m0_wdata = 0; bus.m1_wdata = 0;
    bus.m0_wstrb = 0; bus.m1_wstrb = 0;
    bus.s_rdata = 0; bus.s_ready = 0;
    resetn = 0;
    repeat (2) tick();
    resetn = 1;
    chk("rst_grant",   {31'b0, bus.grant}, 32'h0);
    chk("rst_s_valid", {31'b0, bus.s_valid}, 32'h0);

    // Single read with three-cycle slave latency
    n0 = done_who.size();
    bus.m0_addr = 32'h100; bus.m0_valid = 1;
    tick();
    chk("rd_s_addr", bus.s_addr, 32'h100);
    serve(3, 32'h12345678);
    tick();
    chk("rd_count", done_who.size(), n0 + 1);
    chk("rd_who",   done_who[n0], 0);
    chk("rd_data",  done_rd[n0], 32'h12345678);

    // Tie after reset: m0 first; the following tie goes to m1 first
    n0 = done_who.size();
    bus.m0_addr = 32'h200; bus.m1_addr = 32'h300;
    bus.m0_valid = 1; bus.m1_valid = 1;
    tick();
    serve(1, 32'hA0);
    serve(1, 32'hA1);
    bus.m0_valid = 1; bus.m1_valid = 1;
    tick();
    serve(1, 32'hB0);
    serve(1, 32'hB1);
    tick();
    chk("tie_count", done_who.size(), n0 + 4);
    chk("tie_1", done_who[n0],     0);
    chk("tie_2", done_who[n0 + 1], 1);
    chk("tie_3", done_who[n0 + 2], 1);
    chk("tie_4", done_who[n0 + 3], 0);

    // Timeout: slave never answers
    bus.m1_addr = 32'h400; bus.m1_wstrb = 0; bus.m1_valid = 1;
    tick();
    n = 1;
    while (!bus.m1_ready && n < 20) begin tick(); n++; end
    chk("to_cycles", n, TO);
    chk("to_err",    {31'b0, bus.timeout_err}, 32'h1);
    chk("to_rdata",  bus.m1_rdata, 32'hDEADBEEF);
    tick();
    bus.m1_valid = 0;

    // s_ready on the last allowed cycle beats the timeout
    n0 = done_who.size();
    bus.m0_addr = 32'h500; bus.m0_valid = 1;
    tick();
    serve(TO, 32'hCAFEF00D);
    tick();
    chk("co_who",  done_who[n0], 0);
    chk("co_err",  {31'b0, done_to[n0]}, 32'h0);
    chk("co_data", done_rd[n0], 32'hCAFEF00D);

    // Byte write to the UART
    n0 = done_who.size();
    bus.m1_addr = UART_BASE; bus.m1_wdata = 32'h41; bus.m1_wstrb = 4'b0001; bus.m1_valid = 1;
    tick();
    chk("wr_s_addr",  bus.s_addr, 32'h02000000);
    chk("wr_s_wstrb", {28'b0, bus.s_wstrb}, 32'h1);
    chk("wr_s_wdata", bus.s_wdata, 32'h41);
    serve(2, 32'h0);
    tick();
    chk("wr_count", done_who.size(), n0 + 1);
    chk("wr_who",   done_who[n0], 1);
    bus.m1_wstrb = 0;

    // Requester abandons its request mid-transfer
    n0 = done_who.size();
    bus.m0_addr = 32'h600; bus.m0_valid = 1;
    tick();
    tick();
    bus.m0_valid = 0;
    #1;
    chk("drop_s_valid", {31'b0, bus.s_valid}, 32'h0);
    repeat (3) tick();
    chk("drop_no_ready", done_who.size(), n0);

    // Tie won by m0 leaves m1 preferred for the next tie
    bus.m0_valid = 1; bus.m1_valid = 1;
    tick();
    serve(1, 32'hC0);
    bus.m1_valid = 0;
    tick();

    // Reset in the middle of a transfer clears the preference back to m0
    n0 = done_who.size();
    bus.m0_addr = 32'h700; bus.m0_valid = 1;
    tick();
    chk("mr_s_valid_before", {31'b0, bus.s_valid}, 32'h1);
    resetn = 0;
    tick();
    resetn = 1;
    bus.m0_valid = 0;
    chk("mr_s_valid_after", {31'b0, bus.s_valid}, 32'h0);
    chk("mr_grant",         {31'b0, bus.grant}, 32'h0);
    tick();
    chk("mr_no_ready", done_who.size(), n0);
    bus.m0_valid = 1; bus.m1_valid = 1;
    tick();
    chk("mr_tie_grant", {31'b0, bus.grant}, 32'h0);
    serve(1, 32'hD0);
    serve(1, 32'hD1);
    tick();
    chk("mr_tie_count", done_who.size(), n0 + 2);
    chk("mr_tie_1", done_who[n0],     0);
    chk("mr_tie_2", done_who[n0 + 1], 1);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
